// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants for the time-shared FIR MAC scheduler:
//                default widths and tap count, accumulator width, the
//                67-entry symmetric coefficient table and the FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_SAMPLE_IN_WIDTH  = 16;
    localparam int FIR_SAMPLE_OUT_WIDTH = 2 * FIR_SAMPLE_IN_WIDTH;
    localparam int FIR_TAPS             = 67;
    localparam int FIR_COEF_LEN         = 67;

    // Accumulator needs log2(taps) guard bits above the output width
    function automatic int acc_width(input int out_w, input int taps);
        return out_w + $clog2(taps);
    endfunction

    localparam int ACC_WIDTH = acc_width(FIR_SAMPLE_OUT_WIDTH, FIR_TAPS);

    // Low-pass prototype, symmetric about entry 33 (coef[k] == coef[66-k])
    localparam logic signed [15:0] FIR_COEF [FIR_COEF_LEN] = '{
        16'shFFF8, -16'sd11,  -16'sd14,  -16'sd15,  -16'sd13,  -16'sd7,
         16'sd4,    16'sd19,   16'sd36,   16'sd51,   16'sd59,   16'sd56,
         16'sd38,   16'sd4,   -16'sd43,  -16'sd96,  -16'sd144, -16'sd175,
        -16'sd177, -16'sd138, -16'sd53,   16'sd72,   16'sd222,  16'sd370,
         16'sd483,  16'sd527,  16'sd470,  16'sd292,  16'sd560,  16'sd1480,
         16'sd3100, 16'sd5200, 16'sd7650, 16'sh2676,
         16'sd7650, 16'sd5200, 16'sd3100, 16'sd1480, 16'sd560,  16'sd292,
         16'sd470,  16'sd527,  16'sd483,  16'sd370,  16'sd222,  16'sd72,
        -16'sd53,  -16'sd138, -16'sd177, -16'sd175, -16'sd144, -16'sd96,
        -16'sd43,   16'sd4,    16'sd38,   16'sd56,   16'sd59,   16'sd51,
         16'sd36,   16'sd19,   16'sd4,   -16'sd7,   -16'sd13,  -16'sd15,
        -16'sd14,  -16'sd11,   16'shFFF8
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_mac_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sched_if
//  Description : Sample-in / result-out handshake bundle of the FIR MAC
//                scheduler. master = environment, slave = filter.
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_mac_sched_if
    import fir_pkg::*;
#(
    parameter int SAMPLE_IN_WIDTH  = FIR_SAMPLE_IN_WIDTH,
    parameter int SAMPLE_OUT_WIDTH = 2 * SAMPLE_IN_WIDTH
);

    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic [SAMPLE_IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [SAMPLE_OUT_WIDTH-1:0] out_data;
    logic                        busy;
    logic                        sat_flag;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, sat_flag
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, sat_flag
    );

endinterface
`default_nettype wire

// File: rtl/signed_mul.sv
`default_nettype none
// ============================================================================
//  Module      : signed_mul
//  Description : Combinational full-precision signed multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module signed_mul #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16
) (
    input  logic signed [A_WIDTH-1:0]         i_a,
    input  logic signed [B_WIDTH-1:0]         i_b,
    output logic signed [A_WIDTH+B_WIDTH-1:0] o_p
);

    localparam int c_p_w = A_WIDTH + B_WIDTH;

    // Operands sign-extended to the product width so no precision is lost
    assign o_p = c_p_w'(i_a) * c_p_w'(i_b);

endmodule
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sched
//  Description : FIR filter sharing one signed multiplier across all taps.
//                One sample is accepted in IDLE, TAPS products are summed in
//                MAC, the result is held in DONE until taken.
//  Macro       : FIR_SCHED_SAT_EN - clamp the result to the output range and
//                report it on sat_flag; otherwise two's-complement wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int SAMPLE_IN_WIDTH  = FIR_SAMPLE_IN_WIDTH,
    parameter int SAMPLE_OUT_WIDTH = SAMPLE_IN_WIDTH * 2,
    parameter int TAPS             = FIR_TAPS
) (
    input  logic           CLK,
    input  logic           rst,
    fir_mac_sched_if.slave bus
);

    localparam int c_prod_w = 2 * SAMPLE_IN_WIDTH;
    localparam int c_acc_w  = acc_width(SAMPLE_OUT_WIDTH, TAPS);
    localparam int c_ptr_w  = $clog2(TAPS);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(TAPS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    fir_state_t                        r_state;
    fir_state_t                        w_state_next;
    logic signed [SAMPLE_IN_WIDTH-1:0] r_hist [TAPS];
    logic [c_ptr_w-1:0]                r_wr_ptr;
    logic [c_ptr_w-1:0]                r_rd_ptr;
    logic [c_ptr_w-1:0]                r_k;
    logic signed [c_acc_w-1:0]         r_acc;
    logic [SAMPLE_OUT_WIDTH-1:0]       r_out_data;
    logic                              r_out_valid;

    logic                              w_accept;
    logic                              w_clear_hist;
    logic                              w_mac_last;
    logic                              w_out_hs;
    logic                              w_in_ready;
    logic                              w_busy;
    logic [7:0]                        w_coef_idx;
    logic signed [15:0]                w_coef_tab;
    logic signed [SAMPLE_IN_WIDTH-1:0] w_coef;
    logic signed [SAMPLE_IN_WIDTH-1:0] w_sample;
    logic signed [c_prod_w-1:0]        w_prod;
    logic signed [c_acc_w-1:0]         w_acc_next;
    logic [SAMPLE_OUT_WIDTH-1:0]       w_out_conv;

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b1;
        w_accept     = 1'b0;
        w_clear_hist = 1'b0;
        w_mac_last   = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy       = 1'b0;
                w_in_ready   = !bus.clear;
                w_clear_hist = bus.clear;
                w_accept     = bus.in_valid && !bus.clear;
                if (w_accept) begin
                    w_state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                if (r_k == c_ptr_last) begin
                    w_mac_last   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_out_hs     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sample history ring: clear wipes it, an accepted sample overwrites the oldest slot
    always_ff @(posedge CLK) begin
        if (rst || w_clear_hist) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_accept) begin
            r_hist[r_wr_ptr] <= bus.in_data;
            r_wr_ptr         <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
        end
    end

    // Coefficient lookup; taps beyond the stored table contribute nothing
    always_comb begin
        w_coef_idx = 8'(r_k);
        w_coef_tab = '0;
        if (w_coef_idx < 8'(FIR_COEF_LEN)) begin
            w_coef_tab = FIR_COEF[w_coef_idx[6:0]];
        end
    end

    assign w_coef     = SAMPLE_IN_WIDTH'(w_coef_tab);
    assign w_sample   = r_hist[r_rd_ptr];
    assign w_acc_next = r_acc + c_acc_w'(w_prod);

    signed_mul #(
        .A_WIDTH (SAMPLE_IN_WIDTH),
        .B_WIDTH (SAMPLE_IN_WIDTH)
    ) u_mul (
        .i_a (w_coef),
        .i_b (w_sample),
        .o_p (w_prod)
    );

    // MAC walk: read pointer starts at the newest sample and steps backwards in time
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_k      <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_rd_ptr <= r_wr_ptr;
            r_k      <= '0;
            r_acc    <= '0;
        end else if (r_state == ST_MAC) begin
            r_acc    <= w_acc_next;
            r_rd_ptr <= (r_rd_ptr == '0) ? c_ptr_last : r_rd_ptr - c_ptr_one;
            r_k      <= w_mac_last ? '0 : r_k + c_ptr_one;
        end
    end

`ifdef FIR_SCHED_SAT_EN
    logic [c_acc_w-SAMPLE_OUT_WIDTH:0] w_acc_hi;
    logic                              w_ovf;
    logic                              r_sat;

    // Clamp when the guard bits disagree with the output sign bit
    always_comb begin
        w_acc_hi = w_acc_next[c_acc_w-1:SAMPLE_OUT_WIDTH-1];
        w_ovf    = !((&w_acc_hi) || !(|w_acc_hi));
        if (w_ovf) begin
            w_out_conv = w_acc_next[c_acc_w-1] ? {1'b1, {(SAMPLE_OUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(SAMPLE_OUT_WIDTH-1){1'b1}}};
        end else begin
            w_out_conv = w_acc_next[SAMPLE_OUT_WIDTH-1:0];
        end
    end

    // Clamp indicator captured alongside the result
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_mac_last) begin
            r_sat <= w_ovf;
        end
    end

    assign bus.sat_flag = r_sat;
`else
    // Plain truncation: the result wraps in two's complement
    always_comb begin
        w_out_conv = w_acc_next[SAMPLE_OUT_WIDTH-1:0];
    end

    assign bus.sat_flag = 1'b0;
`endif

    // Result register: loaded with the final sum, held until the consumer takes it
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_mac_last) begin
            r_out_data  <= w_out_conv;
            r_out_valid <= 1'b1;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sched
//  Description : Self-checking bench for fir_mac_sched. Expected results come
//                from a direct convolution over a queue of accepted samples.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_sched;
    import fir_pkg::*;

    localparam int SIW  = 16;
    localparam int SOW  = 32;
    localparam int TAPS = FIR_TAPS;

    logic CLK;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] last_out;
    logic signed [15:0] hist [$];

    fir_mac_sched_if #(.SAMPLE_IN_WIDTH(SIW), .SAMPLE_OUT_WIDTH(SOW)) bus ();

    fir_mac_sched #(
        .SAMPLE_IN_WIDTH  (SIW),
        .SAMPLE_OUT_WIDTH (SOW),
        .TAPS             (TAPS)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y = sum_k coef[k] * x[n-k], missing history reads as zero
    task automatic model_push(input logic [15:0] s);
        hist.push_back(s);
        if (hist.size() > TAPS) void'(hist.pop_front());
    endtask

    task automatic model_eval(output logic [31:0] d, output logic sat);
        longint acc;
        int     idx;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            idx = hist.size() - 1 - k;
            if (idx >= 0) acc += longint'(FIR_COEF[k]) * longint'(hist[idx]);
        end
`ifdef FIR_SCHED_SAT_EN
        if (acc > 64'sd2147483647) begin
            d = 32'h7FFF_FFFF; sat = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            d = 32'h8000_0000; sat = 1'b1;
        end else begin
            d = acc[31:0]; sat = 1'b0;
        end
`else
        d   = acc[31:0];
        sat = 1'b0;
`endif
    endtask

    // One transaction; bp = cycles of held-off out_ready, clr_at/rst_at = MAC step to pulse on
    task automatic send(input logic [15:0] s, input int bp, input int clr_at, input int rst_at);
        int n;
        int guard;
        logic [31:0] exp_d;
        logic exp_s;
        logic stray;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", {63'b0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = s;
        bus.out_ready = (bp == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_push(s);
        model_eval(exp_d, exp_s);
        n = 1;
        while (n <= TAPS + 10) begin
            if (rst_at >= 0 && n - 1 == rst_at) begin
                rst = 1'b1;
                tick();
                check("rst_abort_busy", {63'b0, bus.busy}, 64'd0);
                check("rst_abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
                rst = 1'b0;
                hist.delete();
                stray = 1'b0;
                for (int i = 0; i < TAPS + 4; i++) begin
                    tick();
                    if (bus.out_valid !== 1'b0) stray = 1'b1;
                end
                check("rst_no_late_out_valid", {63'b0, stray}, 64'd0);
                bus.out_ready = 1'b1;
                return;
            end
            bus.clear = (clr_at >= 0 && n - 1 == clr_at);
            if (bus.out_valid === 1'b1) break;
            tick();
            n++;
        end
        bus.clear = 1'b0;
        check("latency_out_valid", n, TAPS + 1);
        check("out_data", {bus.out_data}, {exp_d});
        check("sat_flag", {63'b0, bus.sat_flag}, {63'b0, exp_s});
        last_out = bus.out_data;
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_out_valid", {63'b0, bus.out_valid}, 64'd1);
            check("bp_out_data", {bus.out_data}, {exp_d});
            check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("in_ready_after_handshake", {63'b0, bus.in_ready}, 64'd1);
        check("out_valid_dropped", {63'b0, bus.out_valid}, 64'd0);
    endtask

    // Unit impulse then zeros: each output is one coefficient scaled by 256
    task automatic impulse_run();
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 16'h0100 : 16'h0000, 0, -1, -1);
            if (n == 0)  check("impulse_out0",  {32'b0, last_out}, 64'hFFFF_F800);
            if (n == 33) check("impulse_out33", {32'b0, last_out}, 64'h0026_7600);
        end
    endtask

    initial begin
        int base;
        int step;
        int v;
        int sel;
        logic [31:0] r;
        logic [15:0] s;

        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("reset_busy",      {63'b0, bus.busy},      64'd0);
        check("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("reset_out_data",  {32'b0, bus.out_data},  64'd0);
        check("reset_sat_flag",  {63'b0, bus.sat_flag},  64'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", {63'b0, bus.in_ready}, 64'd1);

        impulse_run();

        // Backpressure on one result
        send(16'h1357, 5, -1, -1);

        // Random ramp, long enough to wrap the history pointer twice
        base = int'($urandom_range(0, 65535));
        step = int'($urandom_range(1, 600));
        for (int i = 0; i < 140; i++) begin
            v = base + i * step;
            s = v[15:0];
            send(s, 0, -1, -1);
        end

        // Random samples biased toward full-scale values, random hold-off
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 3));
            r   = $urandom();
            s   = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : r[15:0];
            send(s, int'($urandom_range(0, 3)), -1, -1);
        end

        // Clear beats a simultaneous in_valid and wipes history
        r             = $urandom();
        bus.clear     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = r[15:0];
        #1;
        check("clear_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
        tick();
        check("clear_no_accept", {63'b0, bus.busy}, 64'd0);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        hist.delete();

        // Clear pulsed mid-MAC is ignored
        r = $urandom();
        send(r[15:0], 0, 10, -1);
        for (int i = 0; i < 3; i++) begin
            r = $urandom();
            send(r[15:0], 0, -1, -1);
        end

        // Reset at MAC step 20 aborts, then the impulse sequence must repeat exactly
        r = $urandom();
        send(r[15:0], 0, -1, 20);
        impulse_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_mac_sched.md
FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

Interface
REQ-001 The block SHALL have parameter SAMPLE_IN_WIDTH, default 16: signed input sample and coefficient width.
REQ-002 The block SHALL have parameter SAMPLE_OUT_WIDTH, default SAMPLE_IN_WIDTH*2: signed output width.
REQ-003 The block SHALL have parameter TAPS, default 67: filter length; 2..128 supported.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port clear, input, 1 bit: zeroes the sample history.
REQ-007 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake.
REQ-008 The block SHALL have port in_data, input, SAMPLE_IN_WIDTH bits: signed sample.
REQ-009 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake.
REQ-010 The block SHALL have port out_data, output, SAMPLE_OUT_WIDTH bits: signed filter result.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port sat_flag, output, 1 bit: out_data was clamped.

Function
REQ-013 The block SHALL be an FSM with states IDLE, MAC and DONE, and SHALL time-share one signed multiplier over all taps.
REQ-014 in_ready SHALL be (state==IDLE) & !clear; a sample is accepted when in_valid & in_ready are both high.
REQ-015 On accept, the block SHALL write in_data to history[wr_ptr], advance wr_ptr modulo TAPS (TAPS-1 wraps to 0), clear the accumulator, set k=0, and go to MAC.
REQ-016 In MAC, each cycle SHALL add coef[k] * history[(newest_ptr - k) mod TAPS] to the accumulator; when k==TAPS-1 the FSM SHALL go to DONE, otherwise k increments.
REQ-017 The product SHALL be a full-precision signed 2*SAMPLE_IN_WIDTH-bit value, and the accumulator SHALL be signed ACC_WIDTH = SAMPLE_OUT_WIDTH+clog2(TAPS) bits.
REQ-018 In DONE, out_valid SHALL be 1, out_data SHALL be registered, and both SHALL stay stable until out_ready; on out_valid & out_ready the FSM SHALL return to IDLE.
REQ-019 Latency: out_valid SHALL rise TAPS+1 cycles after the accept edge, and throughput SHALL be at most one sample per TAPS+2 cycles.
REQ-020 clear in IDLE SHALL zero all history entries and wr_ptr in one cycle; clear SHALL be ignored in MAC and DONE, and clear wins over a simultaneous in_valid.
REQ-021 After clear or reset, missing history SHALL read as zero, so the first TAPS outputs reflect zero-padded history.

Reset
REQ-022 While rst is high: state=IDLE, wr_ptr=0, k=0, accumulator=0, history all zero, out_valid=0, out_data=0, sat_flag=0, busy=0.
REQ-023 rst asserted in MAC or DONE SHALL abort the computation; no out_valid SHALL follow.

Configuration
REQ-024 The macro FIR_SCHED_SAT_EN SHALL select the output conversion.
REQ-025 With FIR_SCHED_SAT_EN defined, out_data SHALL be the accumulator clamped to the signed SAMPLE_OUT_WIDTH range, with sat_flag=1 when a clamp occurred (valid with out_valid).
REQ-026 With FIR_SCHED_SAT_EN undefined, out_data SHALL be accumulator[SAMPLE_OUT_WIDTH-1:0] (two's-complement wrap) and sat_flag SHALL be tied to 0.

Structure
REQ-027 The shared package fir_pkg SHALL hold the default widths and TAPS, the coefficient table (67 symmetric entries, coef[0]=16'hFFF8, coef[33]=16'h2676), the state encoding, and ACC_WIDTH.
REQ-028 The existing signed_mul sub-module SHALL be instantiated once for the product, and there SHALL be no other sub-modules.

Verification
REQ-029 Impulse test: after reset, in_data=16'h0100 then 66 zeros -> outputs SHALL be coef[k]*256, with output 0 = 32'hFFFFF800 and output 33 = 32'h00267600.
REQ-030 Latency test: accept at cycle t with out_ready held 1 -> out_valid SHALL be high only at t+TAPS+1, and in_ready SHALL be high again at t+TAPS+2.
REQ-031 Backpressure test: hold out_ready=0 for 5 cycles in DONE -> out_data and out_valid SHALL stay stable and in_ready SHALL stay 0.
REQ-032 Wrap test: feed 140 samples of a ramp -> each output SHALL match the golden model, including across the wr_ptr wrap.
REQ-033 Clear test: clear and in_valid both high in IDLE -> no accept; clear pulsed mid-MAC -> ignored, and the result SHALL be unchanged.
REQ-034 Reset test: rst pulsed at MAC k=20 -> IDLE next cycle, no out_valid, and the next impulse SHALL produce the REQ-029 sequence.
